// File: rtl/io_ring_pkg.sv
// io_ring_pkg: shared state encoding and counter sizing for the IO ring power sequencer
package io_ring_pkg;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, ENABLE, SETTLE, RUN, FAULT} seq_state_t;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/io_ring_sync2.sv
// io_ring_sync2: W-bit two-flop synchronizer, async active-low reset to 0
// ports: clk, rst_n, d_i (async input), q_o (synchronized output)
module io_ring_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
endmodule

// File: rtl/io_ring_power_seq.sv
// io_ring_power_seq: debounced, staggered IO bank power-up with core reset release and sticky supply fault
// ports: clk, rst_n, supply_ok (per-bank, async), fault_clr -> bank_en, pad_oe_allow, core_rst_n, seq_done, fault, fault_bank
module io_ring_power_seq
  import io_ring_pkg::*;
#(
  parameter int NUM_BANKS    = 4,
  parameter int DEBOUNCE_CYC = 8,
  parameter int STAGGER_CYC  = 4,
  parameter int RELEASE_CYC  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANKS-1:0]         supply_ok,
  input  logic                         fault_clr,
  output logic [NUM_BANKS-1:0]         bank_en,
  output logic                         pad_oe_allow,
  output logic                         core_rst_n,
  output logic                         seq_done,
  output logic                         fault,
  output logic [$clog2(NUM_BANKS)-1:0] fault_bank
);
  localparam int CW = cnt_width(DEBOUNCE_CYC, STAGGER_CYC, RELEASE_CYC);
  localparam int BW = $clog2(NUM_BANKS);
  logic [NUM_BANKS-1:0] ok_s;
  logic                 all_ok;
  seq_state_t           state_q;
  logic [CW-1:0]        cnt_q, cnt_inc;
  logic [BW-1:0]        idx_q, low_bad;
  logic [NUM_BANKS-1:0] bank_en_q;
  logic                 run_q, fault_q;
  logic [BW-1:0]        fault_bank_q;
  io_ring_sync2 #(.W(NUM_BANKS)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(supply_ok), .q_o(ok_s));
  assign all_ok  = &ok_s;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // scanning downward leaves the lowest failing bank as the final answer
  always_comb begin
    low_bad = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) if (!ok_s[i]) low_bad = BW'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      bank_en_q    <= '0;
      run_q        <= 1'b0;
      fault_q      <= 1'b0;
      fault_bank_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (all_ok) begin
            state_q <= DEBOUNCE;
            cnt_q   <= CW'(1);
          end
        DEBOUNCE:
          if (!all_ok) state_q <= IDLE;
          else if (cnt_inc >= CW'(DEBOUNCE_CYC)) begin
            state_q   <= ENABLE;
            bank_en_q <= NUM_BANKS'(1);
            idx_q     <= '0;
            cnt_q     <= '0;
          end else cnt_q <= cnt_inc;
        ENABLE, SETTLE, RUN:
          if (!all_ok) begin
            state_q      <= FAULT;
            bank_en_q    <= '0;
            run_q        <= 1'b0;
            fault_q      <= 1'b0 | 1'b1;
            fault_bank_q <= low_bad;
          end else if (state_q == ENABLE) begin
            if (cnt_inc >= CW'(STAGGER_CYC)) begin
              bank_en_q <= bank_en_q | (NUM_BANKS'(1) << (idx_q + 1'b1));
              idx_q     <= idx_q + 1'b1;
              cnt_q     <= '0;
              if (idx_q == BW'(NUM_BANKS - 2)) state_q <= SETTLE;
            end else cnt_q <= cnt_inc;
          end else if (state_q == SETTLE) begin
            if (cnt_inc >= CW'(RELEASE_CYC)) begin
              state_q <= RUN;
              run_q   <= 1'b1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_inc;
          end
        FAULT:
          if (fault_clr && all_ok) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
    end
  assign bank_en      = bank_en_q;
  assign pad_oe_allow = run_q;
  assign core_rst_n   = run_q;
  assign seq_done     = run_q;
  assign fault        = fault_q;
  assign fault_bank   = fault_bank_q;
endmodule
